// File: rtl/dispatch_thread_iterator_if.sv
// Request/issue handshake bundle for dispatch_thread_iterator.
// slave = the iterator itself, master = the request producer / thread consumer side.
interface dispatch_thread_iterator_if #(
    parameter int TAG_W = 8
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_mask;
    logic [TAG_W-1:0] in_tag;
    logic [5:0]       in_start_pos;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       out_tid;
    logic [TAG_W-1:0] out_tag;
    logic             out_last;
    logic             done;

    modport slave (
        input  flush, in_valid, in_mask, in_tag, in_start_pos, out_ready,
        output in_ready, out_valid, out_tid, out_tag, out_last, done
    );

    modport master (
        output flush, in_valid, in_mask, in_tag, in_start_pos, out_ready,
        input  in_ready, out_valid, out_tid, out_tag, out_last, done
    );
endinterface

// File: rtl/dispatch_thread_iterator.sv
// Walks a 64-bit active-thread mask in round-robin order from a start position, one thread ID per cycle.
// Optional DISPATCH_ITER_PERF_EN adds perf_issued / perf_stall counters.
module dispatch_thread_iterator #(
    parameter int TAG_W = 8,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dispatch_thread_iterator_if.slave bus
`ifdef DISPATCH_ITER_PERF_EN
    ,
    output logic [CNT_W-1:0]      perf_issued,
    output logic [CNT_W-1:0]      perf_stall
`endif
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [0:0]       state;
    logic [63:0]      mask_r;
    logic [5:0]       ptr_r;
    logic [TAG_W-1:0] tag_r;
    logic             done_r;

    logic [6:0]       enc_a;
    logic [6:0]       enc_b;
    logic [5:0]       tid;
    logic             last;
    logic             accept;

    // Start-position priority encoder: {valid, lowest set index >= start}.
    function automatic logic [6:0] penc(input logic [63:0] m, input logic [5:0] start);
        logic [6:0] r;
        r = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (!r[6] && m[i] && (i >= 32'(start))) begin
                r = {1'b1, i[5:0]};
            end
        end
        return r;
    endfunction

    always_comb begin
        enc_a = penc(mask_r, ptr_r);
        enc_b = penc(mask_r, 6'd0);
        tid   = enc_a[6] ? enc_a[5:0] : enc_b[5:0];
        // Gated by state so an idle (empty) mask does not report a last thread.
        last  = (state == ISSUE) && ((mask_r & ~(64'd1 << tid)) == '0);
    end

    assign bus.in_ready  = (state == IDLE) && !bus.flush;
    assign bus.out_valid = (state == ISSUE);
    assign bus.out_tid   = tid;
    assign bus.out_tag   = tag_r;
    assign bus.out_last  = last;
    assign bus.done      = done_r;
    assign accept        = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mask_r <= '0;
            ptr_r  <= '0;
            tag_r  <= '0;
            done_r <= 1'b0;
        end else if (bus.flush) begin
            state  <= IDLE;
            mask_r <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mask_r <= bus.in_mask;
                        tag_r  <= bus.in_tag;
                        ptr_r  <= bus.in_start_pos;
                        if (bus.in_mask == '0) begin
                            done_r <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.out_ready) begin
                        mask_r[tid] <= 1'b0;
                        ptr_r       <= tid + 6'd1;
                        if (last) begin
                            state  <= IDLE;
                            done_r <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DISPATCH_ITER_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                perf_issued <= perf_issued + 1'b1;
            end
            if (bus.out_valid && !bus.out_ready) begin
                perf_stall <= perf_stall + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_thread_iterator.sv
// Self-checking bench for dispatch_thread_iterator: directed scenarios plus randomized masks
// checked against a wrap-around issue-order model.
module tb_dispatch_thread_iterator;
    logic clk;
    logic rst_n;
    int   tests;
    int   failed;
    int   issued_cnt;
    int   stall_cnt;

    dispatch_thread_iterator_if #(.TAG_W(8)) bus ();

`ifdef DISPATCH_ITER_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;
`endif

    dispatch_thread_iterator #(.TAG_W(8), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef DISPATCH_ITER_PERF_EN
        ,
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always 1, 1: toggling 1/0, 2: random
    task automatic run_req(input logic [63:0] m, input logic [7:0] t, input logic [5:0] s,
                           input int mode);
        logic [5:0] q[$];
        logic [5:0] idx;
        int cyc;
        int tog;
        for (int k = 0; k < 64; k++) begin
            idx = 6'((int'(s) + k) % 64);
            if (m[idx]) q.push_back(idx);
        end
        chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.in_valid     = 1'b1;
        bus.in_mask      = m;
        bus.in_tag       = t;
        bus.in_start_pos = s;
        step();
        bus.in_valid = 1'b0;
        bus.in_mask  = {$urandom, $urandom};
        if (q.size() == 0) begin
            chk("empty_no_valid", 64'(bus.out_valid), 64'd0);
            chk("empty_done", 64'(bus.done), 64'd1);
            chk("empty_in_ready", 64'(bus.in_ready), 64'd1);
            return;
        end
        tog = 0;
        cyc = 0;
        while (q.size() > 0 && cyc < 400) begin
            case (mode)
                0: bus.out_ready = 1'b1;
                1: begin bus.out_ready = (tog == 0); tog ^= 1; end
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            chk("out_valid", 64'(bus.out_valid), 64'd1);
            chk("out_tid", 64'(bus.out_tid), 64'(q[0]));
            chk("out_tag", 64'(bus.out_tag), 64'(t));
            chk("out_last", 64'(bus.out_last), 64'(q.size() == 1));
            chk("done_low_issue", 64'(bus.done), 64'd0);
            chk("in_ready_busy", 64'(bus.in_ready), 64'd0);
            if (bus.out_ready) begin
                void'(q.pop_front());
                issued_cnt++;
            end else begin
                stall_cnt++;
            end
            step();
            cyc++;
        end
        if (q.size() != 0) chk("issue_timeout", 64'(q.size()), 64'd0);
        bus.out_ready = 1'b0;
        chk("done_pulse", 64'(bus.done), 64'd1);
        chk("valid_after_last", 64'(bus.out_valid), 64'd0);
        chk("in_ready_back", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] rm;
        tests = 0;
        failed = 0;
        issued_cnt = 0;
        stall_cnt = 0;
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_mask = '0;
        bus.in_tag = '0;
        bus.in_start_pos = '0;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid2", 64'(bus.out_valid), 64'd0);
        chk("rst_out_tid", 64'(bus.out_tid), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);

        run_req(64'h0000_0000_0000_0013, 8'h11, 6'd0, 0);
        step();
        chk("done_one_cycle", 64'(bus.done), 64'd0);
        run_req(64'h8000_0000_0000_0005, 8'h22, 6'd62, 0);
        run_req(64'h0, 8'h5A, 6'd9, 0);
        run_req(64'h0000_0000_0000_0100, 8'h33, 6'd63, 0);
        step();
        chk("done_one_cycle2", 64'(bus.done), 64'd0);

        begin
`ifdef DISPATCH_ITER_PERF_EN
            logic [31:0] pi0;
            logic [31:0] ps0;
            pi0 = perf_issued;
            ps0 = perf_stall;
`endif
            stall_cnt = 0;
            run_req(64'hFFFF_FFFF_FFFF_FFFF, 8'hC3, 6'd17, 1);
`ifdef DISPATCH_ITER_PERF_EN
            chk("perf_issued", 64'(perf_issued - pi0), 64'd64);
            chk("perf_stall", 64'(perf_stall - ps0), 64'(stall_cnt));
`endif
        end

        // flush after two of five handshakes
        bus.in_valid = 1'b1;
        bus.in_mask = 64'h0000_0100_0000_1111;
        bus.in_tag = 8'h77;
        bus.in_start_pos = 6'd0;
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("fl_tid0", 64'(bus.out_tid), 64'd0);
        step();
        chk("fl_tid1", 64'(bus.out_tid), 64'd4);
        step();
        chk("fl_tid2", 64'(bus.out_tid), 64'd8);
        bus.flush = 1'b1;
        #1;
        chk("fl_in_ready", 64'(bus.in_ready), 64'd0);
        step();
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("fl_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_done", 64'(bus.done), 64'd0);
        chk("fl_in_ready2", 64'(bus.in_ready), 64'd1);
        step();
        chk("fl_done2", 64'(bus.done), 64'd0);

        // flush in IDLE blocks acceptance
        bus.in_valid = 1'b1;
        bus.in_mask = 64'h0000_0000_0000_0F00;
        bus.flush = 1'b1;
        #1;
        chk("fl_idle_ready", 64'(bus.in_ready), 64'd0);
        step();
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        #1;
        chk("fl_idle_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_idle_done", 64'(bus.done), 64'd0);
        run_req(64'h0000_0000_0000_0F00, 8'h44, 6'd10, 0);

        for (int n = 0; n < 24; n++) begin
            case (n % 4)
                0: rm = {$urandom, $urandom};
                1: rm = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                2: rm = 64'd1 << $urandom_range(0, 63);
                default: rm = ($urandom_range(0, 2) == 0) ? 64'd0 : {$urandom, $urandom} & 64'hF000_0000_0000_000F;
            endcase
            run_req(rm, 8'($urandom), 6'($urandom), n % 3);
        end

        // reset mid-ISSUE
        bus.in_valid = 1'b1;
        bus.in_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.in_tag = 8'hAB;
        bus.in_start_pos = 6'd5;
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("arst_tid", 64'(bus.out_tid), 64'd0);
        chk("arst_tag", 64'(bus.out_tag), 64'd0);
        chk("arst_last", 64'(bus.out_last), 64'd0);
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        step();
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("post_rst_tag", 64'(bus.out_tag), 64'd0);
        chk("post_rst_done", 64'(bus.done), 64'd0);
`ifdef DISPATCH_ITER_PERF_EN
        chk("post_rst_perf", 64'(perf_issued), 64'd0);
`endif
        run_req(64'h0000_0000_0000_0013, 8'h99, 6'd1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
